// File: rtl/lut_arbiter.sv
// Two-port round-robin arbiter sharing the single combinational read port of mem_LUT.
// The address and the data are registered, so the table sits between two flops. Reads of unpopulated entries are flagged.
module lut_arbiter #(
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned VALID_DEPTH = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data
);

    // One extra bit so a depth equal to 2**ADDR_W can still be represented.
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(VALID_DEPTH);

    logic              r_last;
    logic              r_a_vld;
    logic              r_a_own;
    logic              r_a_err;
    logic [ADDR_W-1:0] r_lut_addr;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_err0;
    logic              r_err1;

    logic              w_gnt0;
    logic              w_gnt1;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic              w_gnt_err;

    // Round-robin pick. A tie goes to the requester that was not granted last.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_gnt_addr = addr0;
        w_gnt_err  = 1'b0;
        if (reset_n) begin
            w_gnt0 = req0 && (!req1 || r_last);
            w_gnt1 = req1 && (!req0 || !r_last);
        end
        if (w_gnt1) begin
            w_gnt_addr = addr1;
        end
        w_gnt_err = ({1'b0, w_gnt_addr} >= DEPTH);
    end

    // Stage A: the arbitration pointer and the registered table address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last     <= 1'b1;
            r_a_vld    <= 1'b0;
            r_a_own    <= 1'b0;
            r_a_err    <= 1'b0;
            r_lut_addr <= '0;
        end else begin
            r_a_vld <= w_gnt0 || w_gnt1;
            if (w_gnt0 || w_gnt1) begin
                r_last     <= w_gnt1;
                r_a_own    <= w_gnt1;
                r_a_err    <= w_gnt_err;
                r_lut_addr <= w_gnt_addr;
            end
        end
    end

    // Stage B: capture the table data into the port that owns the lookup.
    // The other port keeps its previous data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
        end else begin
            r_rvalid0 <= r_a_vld && !r_a_own;
            r_rvalid1 <= r_a_vld && r_a_own;
            if (r_a_vld && !r_a_own) begin
                r_rdata0 <= r_a_err ? '0 : lut_data;
                r_err0   <= r_a_err;
            end
            if (r_a_vld && r_a_own) begin
                r_rdata1 <= r_a_err ? '0 : lut_data;
                r_err1   <= r_a_err;
            end
        end
    end

    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign lut_addr = r_lut_addr;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;
    assign err0     = r_err0;
    assign err1     = r_err1;

endmodule

// File: doc/lut_arbiter.md
# lut_arbiter

Two-port round-robin arbiter and read pipeline for the 32-entry, 8-bit lookup table `mem_LUT`. It shares the table's single combinational read port between requester 0 (core load path) and requester 1 (auxiliary/debug reader). It registers address and data so the table sits between two flops, and flags reads of unpopulated entries. There is one instance per processor, between the requesters and `mem_LUT`.

## Interface
Parameters:
- `ADDR_W`, 5, table address width (32 entries).
- `DATA_W`, 8, table data width.
- `VALID_DEPTH`, 20, number of populated entries; addresses >= this are errors.

Ports:
- `clk`  in  1  single clock, all flops rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  read request; held with its address until granted.
- `addr0`, `addr1`  in  ADDR_W  requested table address.
- `gnt0`, `gnt1`  out  1  combinational accept pulse; the request is consumed on this edge.
- `rvalid0`, `rvalid1`  out  1  registered one-cycle response strobe.
- `rdata0`, `rdata1`  out  DATA_W  response data; valid only while `rvalidN` is high.
- `err0`, `err1`  out  1  qualifies `rvalidN`; the address was out of range.
- `lut_addr`  out  ADDR_W  registered address to `mem_LUT.address`.
- `lut_data`  in  DATA_W  from `mem_LUT.data`; combinational from `lut_addr`.

## Operation
- Arbitration (combinational, every cycle):
  - Only req0 active: grant 0.
  - Only req1 active: grant 1.
  - Both active: grant the requester other than `last`.
  - At most one `gnt` is high per cycle.
  - `last` updates to the granted index on each grant and is unchanged with no grant.
- Stage A, on a grant edge:
  - `lut_addr` <= granted address.
  - `a_vld` <= 1.
  - `a_own` <= granted index.
  - `a_err` <= (address >= VALID_DEPTH).
  - With no grant, `a_vld` <= 0 and `lut_addr` holds.
- Stage B, on each edge, for the requester selected by `a_vld` and `a_own`:
  - `rvalidN` <= 1.
  - `rdataN` <= `a_err` ? 0 : `lut_data`.
  - `errN` <= `a_err`.
- The non-selected requester gets `rvalid` <= 0 and keeps its `rdata` value.
- Pipeline behaviour:
  - No stalls and no backpressure.
  - Responses cannot be refused; requesters must accept the `rvalid` strobe.
  - Sustained throughput is one lookup per cycle, shared.
- Address range checks:
  - `addr` values up to 31 are legal to drive.
  - Out-of-range addresses still drive `lut_addr` but return 0 with `err` set.
- State: the `last` pointer, stage A registers and stage B registers. There is no FSM beyond that pipeline.

## Timing
- Reset (async assert, sync deassert by the system) drives:
  - `last` = 1, so req0 wins the first tie.
  - `a_vld`, `a_own`, `a_err` = 0.
  - `lut_addr` = 0.
  - All `rvalidN`, `errN` = 0.
  - All `rdataN` = 0.
- `gnt` outputs are 0 while `reset_n` is low, whatever `req` does.
- Latency: grant in cycle N gives `lut_addr` valid in N+1 and `rvalid`/`rdata` in N+2.
- Back-to-back grants produce back-to-back responses in grant order. Responses are never reordered.
- Simultaneous requests alternate every cycle: 0, 1, 0, 1…
- A continuous single requester is granted every cycle.
- Dropping `req` without a grant is legal; nothing is issued.
- Reset asserted mid-flight:
  - In-flight lookups in A and B are discarded with no `rvalid`.
  - Requesters re-issue after reset.
- `req` high during the grant cycle is consumed. The requester must either drop `req` or present a new address on the next cycle.

## Test plan
- Reset, then req0 with addr0=3 for one cycle -> gnt0 in that cycle; rvalid0=1, rdata0=63, err0=0 two cycles later; rvalid1 stays 0.
- req0 (addr 5) and req1 (addr 10) both held for 4 cycles -> grant order 0,1,0,1; rdata sequence 65,70,65,70 on alternating ports, starting 2 cycles after the first grant.
- req1 alone at addr 19, then addr 20 -> rdata1=79 with err1=0; then rdata1=0 with err1=1. Also addr 31 -> err1=1.
- req0 continuous with addresses 0..7 on consecutive cycles -> 8 consecutive rvalid0 pulses with data 60..67; req1 absent gets no grant.
- Grant issued, then `reset_n` pulled low one cycle later -> no rvalid after reset. After release, all outputs are 0, and the first tie goes to req0.
- After a req1-only grant, issue a simultaneous tie -> gnt0 wins, confirming `last` tracks single-requester grants.
